// File: rtl/fir_xifu_pkg.sv
// ---------------------------------------------------------------------------
// fir_xifu_pkg
// Shared definitions for the offload-ID scoreboard:
//   NUM_ID_DEFAULT : default number of tracked offload IDs
//   entry_state_e  : lifecycle state of one scoreboard entry
// ---------------------------------------------------------------------------
package fir_xifu_pkg;

    localparam int unsigned NUM_ID_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_ISSUED    = 2'd1,
        ST_COMMITTED = 2'd2,
        ST_KILLED    = 2'd3
    } entry_state_e;

endpackage

// File: rtl/fir_xifu_scoreboard_if.sv
// ---------------------------------------------------------------------------
// fir_xifu_scoreboard_if
// Issue/commit request bundle going from the core into the scoreboard.
//   issue_valid  : an instruction with issue_id was accepted by ID this cycle
//   issue_id     : ID of the issued instruction
//   commit_valid : core commit strobe
//   commit_id    : ID addressed by the commit
//   commit_kill  : commit is a kill (qualified by commit_valid)
// Modports: master (core side, drives) / slave (scoreboard side, receives).
// ---------------------------------------------------------------------------
interface fir_xifu_scoreboard_if
    import fir_xifu_pkg::*;
#(
    parameter int unsigned NUM_ID = NUM_ID_DEFAULT
);

    localparam int unsigned ID_W = $clog2(NUM_ID);

    logic            issue_valid;
    logic [ID_W-1:0] issue_id;
    logic            commit_valid;
    logic [ID_W-1:0] commit_id;
    logic            commit_kill;

    modport master (
        output issue_valid, issue_id, commit_valid, commit_id, commit_kill
    );

    modport slave (
        input issue_valid, issue_id, commit_valid, commit_id, commit_kill
    );

endinterface

// File: rtl/fir_xifu_sb_entry.sv
// ---------------------------------------------------------------------------
// fir_xifu_sb_entry
// Lifecycle FSM for a single offload ID (FREE/ISSUED/COMMITTED/KILLED).
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush         : drop the entry, overrides everything else
//   clear         : entry retired in WB, returns it to FREE
//   commit        : effective (de-duplicated) commit addressed to this entry
//   kill          : the commit is a kill
//   issue         : an instruction with this ID was accepted by ID
//   issued        : registered, entry is not FREE
//   committed     : registered, entry is COMMITTED
//   killed        : registered, entry is KILLED
//   busy_next     : next-state is not FREE (feeds the outstanding count)
//   ex_commit     : combinational commit view for EX
//   err           : combinational protocol violation on this entry
// ---------------------------------------------------------------------------
module fir_xifu_sb_entry
    import fir_xifu_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush,
    input  logic clear,
    input  logic commit,
    input  logic kill,
    input  logic issue,
    output logic issued,
    output logic committed,
    output logic killed,
    output logic busy_next,
    output logic ex_commit,
    output logic err
);

    entry_state_e state_q;
    entry_state_e state_d;

    // NOTE: state registers use non-blocking assignments so every entry
    // samples the same pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the if/else tree can leave a signal unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        err       = 1'b0;
        ex_commit = 1'b0;

        if (flush) begin
            state_d = ST_FREE;
        end else if (clear) begin
            // A retiring ID may be handed out again in the same cycle.
            state_d = issue ? ST_ISSUED : ST_FREE;
        end else begin
            // The commit is judged against the pre-issue state, so an issue
            // and a commit to a FREE entry together leave it ISSUED + error.
            if (commit) begin
                if (state_q == ST_ISSUED) begin
                    state_d = kill ? ST_KILLED : ST_COMMITTED;
                end else begin
                    err = 1'b1;
                end
            end
            if (issue) begin
                if (state_q == ST_FREE) begin
                    state_d = ST_ISSUED;
                end else begin
                    err = 1'b1;
                end
            end
        end

        if (!flush && !clear) begin
            ex_commit = (commit && !kill && (state_q == ST_ISSUED))
                      || (state_q == ST_COMMITTED);
        end
    end

    assign busy_next = (state_d != ST_FREE);
    assign issued    = (state_q != ST_FREE);
    assign committed = (state_q == ST_COMMITTED);
    assign killed    = (state_q == ST_KILLED);

endmodule

// File: rtl/fir_xifu_scoreboard.sv
// ---------------------------------------------------------------------------
// fir_xifu_scoreboard
// Tracks the lifecycle of NUM_ID offload IDs between issue, commit and
// write-back retirement, and reports protocol violations.
// Parameters:
//   NUM_ID       : tracked IDs (power of two, 4..64)
//   DEDUP_COMMIT : ignore a commit repeating the previous cycle's commit ID
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   xif           : issue/commit request bundle (slave modport)
//   clear_i       : per-ID retire from WB
//   flush_i       : synchronous flush of all entries
//   issued_o      : registered, entry not FREE
//   committed_o   : registered, entry COMMITTED
//   killed_o      : registered, entry KILLED
//   ex_commit_o   : combinational commit view for EX
//   outstanding_o : registered count of non-FREE entries
//   full_o        : registered, every entry busy
//   err_o         : registered one-cycle protocol-violation pulse
// ---------------------------------------------------------------------------
module fir_xifu_scoreboard
    import fir_xifu_pkg::*;
#(
    parameter int unsigned NUM_ID       = NUM_ID_DEFAULT,
    parameter bit          DEDUP_COMMIT = 1'b1,
    localparam int unsigned ID_W        = $clog2(NUM_ID),
    localparam int unsigned CNT_W       = $clog2(NUM_ID) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    fir_xifu_scoreboard_if.slave  xif,
    input  logic [NUM_ID-1:0]     clear_i,
    input  logic                  flush_i,
    output logic [NUM_ID-1:0]     issued_o,
    output logic [NUM_ID-1:0]     committed_o,
    output logic [NUM_ID-1:0]     killed_o,
    output logic [NUM_ID-1:0]     ex_commit_o,
    output logic [CNT_W-1:0]      outstanding_o,
    output logic                  full_o,
    output logic                  err_o
);

    logic            hist_valid_q;
    logic [ID_W-1:0] hist_id_q;
    logic            commit_dup;
    logic            commit_eff;

    logic [NUM_ID-1:0] busy_next;
    logic [NUM_ID-1:0] entry_err;
    logic [CNT_W-1:0]  cnt_d;

    // The core may hold the commit strobe for more than one cycle; only the
    // first cycle of such a run counts as a real commit.
    assign commit_dup = DEDUP_COMMIT && hist_valid_q && (hist_id_q == xif.commit_id);
    assign commit_eff = xif.commit_valid && !commit_dup;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_valid_q <= 1'b0;
            hist_id_q    <= '0;
        end else if (flush_i) begin
            hist_valid_q <= 1'b0;
        end else begin
            hist_valid_q <= xif.commit_valid;
            hist_id_q    <= xif.commit_id;
        end
    end

    for (genvar i = 0; i < NUM_ID; i++) begin : g_entry
        fir_xifu_sb_entry u_entry (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .flush     (flush_i),
            .clear     (clear_i[i]),
            .commit    (commit_eff && (xif.commit_id == ID_W'(i))),
            .kill      (xif.commit_kill),
            .issue     (xif.issue_valid && (xif.issue_id == ID_W'(i))),
            .issued    (issued_o[i]),
            .committed (committed_o[i]),
            .killed    (killed_o[i]),
            .busy_next (busy_next[i]),
            .ex_commit (ex_commit_o[i]),
            .err       (entry_err[i])
        );
    end

    // CNT_W is one bit wider than ID_W, so NUM_ID itself is representable
    // and the count can never wrap.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_ID; i++) begin
            cnt_d = cnt_d + CNT_W'(busy_next[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_o <= '0;
            full_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            outstanding_o <= cnt_d;
            full_o        <= (cnt_d == CNT_W'(NUM_ID));
            err_o         <= |entry_err;
        end
    end

endmodule

// File: tb/tb_fir_xifu_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_fir_xifu_scoreboard
// Self-checking bench for fir_xifu_scoreboard (NUM_ID=16, DEDUP_COMMIT=1).
// A behavioural reference model predicts each cycle's outputs when the
// stimulus is driven; the prediction is queued and compared once the DUT
// has produced the corresponding outputs.
// ---------------------------------------------------------------------------
module tb_fir_xifu_scoreboard;

    localparam int N = 16;

    localparam logic [1:0] M_FREE = 2'd0;
    localparam logic [1:0] M_ISS  = 2'd1;
    localparam logic [1:0] M_COM  = 2'd2;
    localparam logic [1:0] M_KIL  = 2'd3;

    typedef struct packed {
        logic [N-1:0] issued;
        logic [N-1:0] committed;
        logic [N-1:0] killed;
        logic [N-1:0] ex_commit;
        logic [4:0]   outstanding;
        logic         full;
        logic         err;
    } snap_t;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [N-1:0] clear_i;
    logic         flush_i;
    logic [N-1:0] issued_o;
    logic [N-1:0] committed_o;
    logic [N-1:0] killed_o;
    logic [N-1:0] ex_commit_o;
    logic [4:0]   outstanding_o;
    logic         full_o;
    logic         err_o;

    fir_xifu_scoreboard_if #(.NUM_ID(N)) xif ();

    fir_xifu_scoreboard #(.NUM_ID(N), .DEDUP_COMMIT(1'b1)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .xif           (xif),
        .clear_i       (clear_i),
        .flush_i       (flush_i),
        .issued_o      (issued_o),
        .committed_o   (committed_o),
        .killed_o      (killed_o),
        .ex_commit_o   (ex_commit_o),
        .outstanding_o (outstanding_o),
        .full_o        (full_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    int    checks = 0;
    int    errors = 0;
    snap_t exp_q[$];
    snap_t obs_q[$];
    snap_t last_obs;

    logic [1:0] m_st [N];
    logic       m_hv;
    logic [3:0] m_hid;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_st[i] = M_FREE;
        m_hv  = 1'b0;
        m_hid = 4'd0;
    endtask

    // One clock cycle: drive inputs, predict, let the DUT clock, sample.
    task automatic cycle(input logic iv, input logic [3:0] iid,
                         input logic cv, input logic [3:0] cid, input logic ck,
                         input logic [N-1:0] clr, input logic fl);
        snap_t      e;
        snap_t      o;
        logic [1:0] nx [N];
        logic       eff;
        logic       errv;
        int         cnt;
        xif.issue_valid  = iv;
        xif.issue_id     = iid;
        xif.commit_valid = cv;
        xif.commit_id    = cid;
        xif.commit_kill  = ck;
        clear_i          = clr;
        flush_i          = fl;
        #1;
        o           = '0;
        o.ex_commit = ex_commit_o;
        e           = '0;
        eff         = cv && !(m_hv && (m_hid == cid));
        errv        = 1'b0;
        for (int i = 0; i < N; i++) begin
            logic ci;
            logic ii;
            ci    = eff && (cid == 4'(i));
            ii    = iv && (iid == 4'(i));
            nx[i] = m_st[i];
            e.ex_commit[i] = !fl && !clr[i] &&
                             ((ci && !ck && (m_st[i] == M_ISS)) || (m_st[i] == M_COM));
            if (fl) begin
                nx[i] = M_FREE;
            end else if (clr[i]) begin
                nx[i] = ii ? M_ISS : M_FREE;
            end else begin
                if (ci) begin
                    if (m_st[i] == M_ISS) nx[i] = ck ? M_KIL : M_COM;
                    else                  errv  = 1'b1;
                end
                if (ii) begin
                    if (m_st[i] == M_FREE) nx[i] = M_ISS;
                    else                   errv  = 1'b1;
                end
            end
        end
        if (fl) begin
            m_hv = 1'b0;
        end else begin
            m_hv  = cv;
            m_hid = cid;
        end
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            m_st[i]        = nx[i];
            e.issued[i]    = (nx[i] != M_FREE);
            e.committed[i] = (nx[i] == M_COM);
            e.killed[i]    = (nx[i] == M_KIL);
            if (nx[i] != M_FREE) cnt++;
        end
        e.outstanding = 5'(cnt);
        e.full        = (cnt == N);
        e.err         = errv;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        o.issued      = issued_o;
        o.committed   = committed_o;
        o.killed      = killed_o;
        o.outstanding = outstanding_o;
        o.full        = full_o;
        o.err         = err_o;
        obs_q.push_back(o);
        last_obs = o;
        xif.issue_valid  = 1'b0;
        xif.issue_id     = 4'd0;
        xif.commit_valid = 1'b0;
        xif.commit_id    = 4'd0;
        xif.commit_kill  = 1'b0;
        clear_i          = '0;
        flush_i          = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #12;
        checks++;
        if ({issued_o, committed_o, killed_o, outstanding_o, full_o, err_o} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h required 0",
                     {issued_o, committed_o, killed_o, outstanding_o, full_o, err_o});
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic test_commit_flow();
        cycle(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, '0, 1'b0);
        idle();
        cycle(1'b0, 4'd0, 1'b1, 4'd3, 1'b0, '0, 1'b0);
        checks++;
        if (last_obs.ex_commit[3] !== 1'b1 || last_obs.committed[3] !== 1'b1) begin
            errors++;
            $display("FAIL commit_flow_commit: got ex=%b com=%b required ex=1 com=1",
                     last_obs.ex_commit[3], last_obs.committed[3]);
        end
        cycle(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0008, 1'b0);
        checks++;
        if (last_obs.committed[3] !== 1'b0 || last_obs.outstanding !== 5'd0) begin
            errors++;
            $display("FAIL commit_flow_clear: got com=%b out=%0d required com=0 out=0",
                     last_obs.committed[3], last_obs.outstanding);
        end
        while (exp_q.size() > 0) begin
            snap_t e;
            snap_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL commit_flow_cycle: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_kill_dedup();
        cycle(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 4'd0, 1'b1, 4'd5, 1'b1, '0, 1'b0);
            checks++;
            if (last_obs.killed[5] !== 1'b1 || last_obs.ex_commit[5] !== 1'b0 ||
                last_obs.err !== 1'b0) begin
                errors++;
                $display("FAIL kill_dedup_%0d: got kil=%b ex=%b err=%b required kil=1 ex=0 err=0",
                         k, last_obs.killed[5], last_obs.ex_commit[5], last_obs.err);
            end
        end
        idle();
        while (exp_q.size() > 0) begin
            snap_t e;
            snap_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL kill_dedup_cycle: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_bad_commit();
        cycle(1'b0, 4'd0, 1'b1, 4'd7, 1'b0, '0, 1'b0);
        checks++;
        if (last_obs.err !== 1'b1 || last_obs.issued[7] !== 1'b0) begin
            errors++;
            $display("FAIL bad_commit_pulse: got err=%b iss7=%b required err=1 iss7=0",
                     last_obs.err, last_obs.issued[7]);
        end
        idle();
        checks++;
        if (last_obs.err !== 1'b0) begin
            errors++;
            $display("FAIL bad_commit_width: got err=%b required 0", last_obs.err);
        end
        while (exp_q.size() > 0) begin
            snap_t e;
            snap_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL bad_commit_cycle: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_full();
        cycle(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, '0, 1'b1);
        for (int i = 0; i < N; i++) cycle(1'b1, 4'(i), 1'b0, 4'd0, 1'b0, '0, 1'b0);
        checks++;
        if (last_obs.full !== 1'b1 || last_obs.outstanding !== 5'd16) begin
            errors++;
            $display("FAIL full_set: got full=%b out=%0d required full=1 out=16",
                     last_obs.full, last_obs.outstanding);
        end
        cycle(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, '0, 1'b0);
        checks++;
        if (last_obs.err !== 1'b1 || last_obs.outstanding !== 5'd16) begin
            errors++;
            $display("FAIL full_overissue: got err=%b out=%0d required err=1 out=16",
                     last_obs.err, last_obs.outstanding);
        end
        cycle(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0001, 1'b0);
        checks++;
        if (last_obs.err !== 1'b0 || last_obs.outstanding !== 5'd16 ||
            last_obs.issued[0] !== 1'b1) begin
            errors++;
            $display("FAIL full_reuse: got err=%b out=%0d iss0=%b required err=0 out=16 iss0=1",
                     last_obs.err, last_obs.outstanding, last_obs.issued[0]);
        end
        while (exp_q.size() > 0) begin
            snap_t e;
            snap_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL full_cycle: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_flush();
        cycle(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, '0, 1'b1);
        for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0, 4'd0, 1'b0, '0, 1'b0);
        cycle(1'b0, 4'd0, 1'b1, 4'd1, 1'b0, '0, 1'b0);
        cycle(1'b0, 4'd0, 1'b1, 4'd2, 1'b0, '0, 1'b0);
        cycle(1'b0, 4'd0, 1'b1, 4'd3, 1'b0, '0, 1'b1);
        checks++;
        if (last_obs !== '0) begin
            errors++;
            $display("FAIL flush_all_zero: got %h required 0", last_obs);
        end
        while (exp_q.size() > 0) begin
            snap_t e;
            snap_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL flush_cycle: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            logic [N-1:0] clr;
            clr = '0;
            if ($urandom_range(0, 3) == 0) clr[$urandom_range(0, 7)] = 1'b1;
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), clr, ($urandom_range(0, 31) == 0));
        end
        while (exp_q.size() > 0) begin
            snap_t e;
            snap_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back_cycle: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, '0, 1'b1);
        for (int i = 8; i < 16; i++) cycle(1'b1, 4'(i), 1'b0, 4'd0, 1'b0, '0, 1'b0);
        checks++;
        if (last_obs.outstanding !== 5'd8) begin
            errors++;
            $display("FAIL reset_mid_setup: got out=%0d required 8", last_obs.outstanding);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({issued_o, committed_o, killed_o, outstanding_o, full_o, err_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h required 0",
                     {issued_o, committed_o, killed_o, outstanding_o, full_o, err_o});
        end
        #4;
        rst_ni = 1'b1;
        model_reset();
        cycle(1'b1, 4'd9, 1'b0, 4'd0, 1'b0, '0, 1'b0);
        checks++;
        if (last_obs.issued !== 16'h0200 || last_obs.outstanding !== 5'd1 ||
            last_obs.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_reissue: got iss=%h out=%0d err=%b required iss=0200 out=1 err=0",
                     last_obs.issued, last_obs.outstanding, last_obs.err);
        end
        idle();
        while (exp_q.size() > 0) begin
            snap_t e;
            snap_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid_cycle: got %h required %h", o, e);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        xif.issue_valid  = 1'b0;
        xif.issue_id     = 4'd0;
        xif.commit_valid = 1'b0;
        xif.commit_id    = 4'd0;
        xif.commit_kill  = 1'b0;
        clear_i          = '0;
        flush_i          = 1'b0;
        rst_ni           = 1'b0;
        model_reset();

        test_reset();
        test_commit_flow();
        test_kill_dedup();
        test_bad_commit();
        test_full();
        test_flush();
        test_back_to_back();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_xifu_scoreboard.md
FIR_XIFU_SCOREBOARD -- requirements
Module: fir_xifu_scoreboard

Interface
REQ-001 Parameter NUM_ID, default 16, meaning number of tracked offload IDs (power of two, 4..64).
REQ-002 Parameter DEDUP_COMMIT, default 1, meaning suppress a repeated back-to-back commit of the same ID when 1.
REQ-003 Derived constants ID_W = log2(NUM_ID) and CNT_W = log2(NUM_ID)+1, not overridable.
REQ-004 Port clk_i  input  1  clock, all state updates on rising edge.
REQ-005 Port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 Port issue_valid_i  input  1  an instruction with issue_id_i was accepted by the ID stage this cycle.
REQ-007 Port issue_id_i  input  ID_W  ID of the issued instruction.
REQ-008 Port commit_valid_i  input  1  core commit strobe.
REQ-009 Port commit_id_i  input  ID_W  ID addressed by the commit.
REQ-010 Port commit_kill_i  input  1  commit is a kill, qualified by commit_valid_i.
REQ-011 Port clear_i  input  NUM_ID  per-ID clear from WB, the entry has retired.
REQ-012 Port flush_i  input  1  synchronous flush of all entries.
REQ-013 Port issued_o  output  NUM_ID  registered: entry is not FREE.
REQ-014 Port committed_o  output  NUM_ID  registered: entry is COMMITTED.
REQ-015 Port killed_o  output  NUM_ID  registered: entry is KILLED.
REQ-016 Port ex_commit_o  output  NUM_ID  combinational commit view for EX.
REQ-017 Port outstanding_o  output  CNT_W  registered count of non-FREE entries.
REQ-018 Port full_o  output  1  registered: outstanding_o == NUM_ID.
REQ-019 Port err_o  output  1  registered one-cycle pulse on a protocol violation.

Function
REQ-020 Each entry SHALL hold one of FREE, ISSUED, COMMITTED, KILLED; all outputs except ex_commit_o SHALL be driven from registered state, with one cycle of latency.
REQ-021 Per-entry next-state priority SHALL be: flush_i, then clear, then commit, then issue, then hold.
REQ-022 flush_i SHALL force every entry to FREE next cycle, ignoring all other inputs in that cycle, and SHALL not raise err_o.
REQ-023 clear_i[i] SHALL force entry i to FREE; a clear on a FREE entry is a no-op and not an error.
REQ-024 The effective commit SHALL be commit_valid_i, except that with DEDUP_COMMIT=1 it is suppressed when the previous cycle had commit_valid_i=1 with the same commit_id_i.
REQ-025 An effective commit to an ISSUED entry SHALL move it to KILLED if commit_kill_i=1, else to COMMITTED.
REQ-026 An effective commit to a FREE, COMMITTED or KILLED entry SHALL leave the entry unchanged and pulse err_o next cycle.
REQ-027 An issue to a FREE entry, or to an entry cleared in the same cycle, SHALL move it to ISSUED (ID reuse).
REQ-028 An issue to any other entry SHALL be dropped and pulse err_o; the upstream stage must stall on full_o.
REQ-029 Issue and commit to the same ID in the same cycle SHALL leave the entry ISSUED (the commit sees the pre-issue state) and pulse err_o.
REQ-030 ex_commit_o[i] SHALL equal (effective non-kill commit to i this cycle while entry i is ISSUED) OR (entry i is COMMITTED), and SHALL be masked to 0 when flush_i or clear_i[i] is high.
REQ-031 outstanding_o SHALL equal the popcount of next-state non-FREE entries, registered; it SHALL never exceed NUM_ID or wrap.
REQ-032 The dedup history register SHALL reset to invalid and SHALL be invalidated by flush_i.

Reset
REQ-033 On rst_ni low, all entries SHALL go to FREE and issued_o, committed_o, killed_o, outstanding_o, full_o and err_o SHALL be 0, asynchronously.
REQ-034 A reset asserted mid-operation SHALL discard all pending state, with no err_o after release.

Structure
REQ-035 The entry-state enum typedef and the NUM_ID default SHALL live in fir_xifu_pkg.
REQ-036 The per-entry FSM SHALL be a sub-module fir_xifu_sb_entry, instantiated NUM_ID times; the popcount, dedup and err logic SHALL stay in the top level.

Verification
REQ-037 Issue ID 3, commit ID 3 (kill=0) two cycles later -> ex_commit_o[3]=1 in the same cycle, committed_o[3]=1 next cycle; clear_i[3] -> committed_o[3]=0 and outstanding_o back to 0.
REQ-038 Commit ID 5 with kill=1 for two consecutive cycles (DEDUP_COMMIT=1) -> killed_o[5]=1, ex_commit_o[5]=0, err_o stays 0.
REQ-039 Commit to never-issued ID 7 -> err_o pulses exactly one cycle, entry 7 stays FREE.
REQ-040 Issue all 16 IDs -> full_o=1 and outstanding_o=16; a 17th issue to ID 0 -> err_o, state unchanged; clear_i[0] plus issue ID 0 in the same cycle -> ID 0 ISSUED, outstanding_o=16.
REQ-041 With 4 entries ISSUED/COMMITTED, assert flush_i together with a commit -> all outputs 0 next cycle, no err_o.
REQ-042 Assert rst_ni low for half a cycle with 8 outstanding -> all outputs 0 immediately, and normal issue works after release.
